fp_issue: RTL

Request/response issue stage placed directly upstream of `fp_exe`. It accepts one floating-point operation from the integer pipeline over a valid/ready handshake and registers the operands. It drives `fp_exe` with a one-cycle `enable` strobe, then waits for `fp_exe_o.ready`, which is immediate for single-cycle ops and delayed for FMA/div/sqrt. It holds the result in a response register until it is consumed and accumulates the RISC-V `fflags` sticky bits.

---
 rtl/fp_issue.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_issue.sv
// fp_issue: one-deep issue stage in front of fp_exe with a response register and sticky fflags.
// Define FP_ISSUE_TIMEOUT_EN to enable the WAIT-state watchdog (limit set by TIMEOUT).
package fp_wire;

    typedef struct packed {
        logic       fmadd;
        logic       fmsub;
        logic       fnmadd;
        logic       fnmsub;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fsgnj;
        logic       fcmp;
        logic       fmax;
        logic       fclass;
        logic       fmv_i2f;
        logic       fmv_f2i;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

endpackage

module fp_issue
    import fp_wire::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_data1,
    input  logic [63:0]      req_data2,
    input  logic [63:0]      req_data3,
    input  fp_operation_type req_op,
    input  logic [1:0]       req_fmt,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output fp_exe_in_type    fp_exe_i,
    input  fp_exe_out_type   fp_exe_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic             handshake;
    logic             timed_out;
    logic             enable;

    logic [63:0]      data1_q;
    logic [63:0]      data2_q;
    logic [63:0]      data3_q;
    fp_operation_type op_q;
    logic [1:0]       fmt_q;
    logic [2:0]       rm_q;
    logic [TAG_W-1:0] tag_q;

    assign accept    = req_valid && req_ready;
    assign handshake = (state == RESP) && rsp_ready;
    // ready is only honoured while an op is outstanding; stray pulses elsewhere are dropped
    assign capture   = ((state == EXEC) || (state == WAIT)) && fp_exe_o.ready;
    assign rsp_valid = (state == RESP);

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Clearing in EXEC is equivalent to clearing on WAIT entry: EXEC is the only way in.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == EXEC) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timed_out   = (state == WAIT) && !fp_exe_o.ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_timeout = timeout_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (capture) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = EXEC;
            EXEC: state_nxt = capture ? RESP : WAIT;
            WAIT: if (capture || timed_out) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = req_valid ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = reset && ((state == IDLE) || ((state == RESP) && rsp_ready));
        enable    = (state == EXEC);
        fp_exe_i.data1  = data1_q;
        fp_exe_i.data2  = data2_q;
        fp_exe_i.data3  = data3_q;
        fp_exe_i.op     = op_q;
        fp_exe_i.fmt    = fmt_q;
        fp_exe_i.rm     = rm_q;
        fp_exe_i.enable = enable;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            op_q    <= '0;
            fmt_q   <= '0;
            rm_q    <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            data1_q <= req_data1;
            data2_q <= req_data2;
            data3_q <= req_data3;
            op_q    <= req_op;
            fmt_q   <= req_fmt;
            rm_q    <= req_rm;
            tag_q   <= req_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
        end else if (capture) begin
            rsp_result <= fp_exe_o.result;
            rsp_flags  <= fp_exe_o.flags;
            rsp_tag    <= tag_q;
        end else if (timed_out) begin
            rsp_result <= '0;
            rsp_flags  <= 5'b10000;
            rsp_tag    <= tag_q;
        end
    end

    // A clear coincident with a handshake keeps the flags of the op being retired.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fflags <= '0;
        end else if (handshake) begin
            fflags <= fflags_clr ? rsp_flags : (fflags | rsp_flags);
        end else if (fflags_clr) begin
            fflags <= '0;
        end
    end

endmodule
